// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: FSM states, ALU operations,
// opcode/funct constants and the supported-instruction check used in DECODE.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // OP_HALT is deliberately absent so it falls into the unsupported path.
    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: is_supported = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_BEQ, OP_BGTZ, OP_ADDI, OP_LW, OP_SW: is_supported = 1'b1;
            default:  is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Control unit of the multicycle core: state register plus per-state decode
// of datapath strobes. The current state is exported on o_state.
module mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    input  logic       i_a_eq_b,
    input  logic       i_a_gtz,
    output state_t     o_state,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_addr_sel_alu,
    output logic       o_ir_we,
    output logic       o_ab_we,
    output logic       o_aluout_we,
    output logic       o_alu_src_imm,
    output alu_op_t    o_alu_op,
    output logic       o_mdr_we,
    output logic       o_rf_we,
    output logic       o_wb_rt,
    output logic       o_wb_mdr,
    output logic       o_pc_inc,
    output logic       o_pc_branch,
    output logic       o_pc_jump
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    assign o_state = r_state;

    // Memory handshake: mem_req stays high with a stable address/we/wdata until
    // a cycle where mem_ready is also high; that cycle is the single transfer.
    // Gating with rst_n drops the request the instant reset asserts.
    always_comb begin
        w_next         = r_state;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_addr_sel_alu = 1'b0;
        o_ir_we        = 1'b0;
        o_ab_we        = 1'b0;
        o_aluout_we    = 1'b0;
        o_alu_src_imm  = 1'b0;
        o_alu_op       = ALU_ADD;
        o_mdr_we       = 1'b0;
        o_rf_we        = 1'b0;
        o_wb_rt        = 1'b0;
        o_wb_mdr       = 1'b0;
        o_pc_inc       = 1'b0;
        o_pc_branch    = 1'b0;
        o_pc_jump      = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req = rst_n;
                if (i_mem_ready) begin
                    o_ir_we  = 1'b1;
                    o_pc_inc = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_supported(i_opcode, i_funct)) begin
                    o_ab_we = 1'b1;
                    w_next  = S_EXEC;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_EXEC: begin
                case (i_opcode)
                    OP_RTYPE: begin
                        o_aluout_we = 1'b1;
                        w_next      = S_WB;
                        case (i_funct)
                            FN_SUB:  o_alu_op = ALU_SUB;
                            FN_AND:  o_alu_op = ALU_AND;
                            FN_OR:   o_alu_op = ALU_OR;
                            FN_SLT:  o_alu_op = ALU_SLT;
                            default: o_alu_op = ALU_ADD;
                        endcase
                    end
                    OP_ADDI: begin
                        o_aluout_we   = 1'b1;
                        o_alu_src_imm = 1'b1;
                        w_next        = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        o_aluout_we   = 1'b1;
                        o_alu_src_imm = 1'b1;
                        w_next        = S_MEM;
                    end
                    OP_BEQ: begin
                        o_pc_branch = i_a_eq_b;
                        w_next      = S_FETCH;
                    end
                    OP_BGTZ: begin
                        o_pc_branch = i_a_gtz;
                        w_next      = S_FETCH;
                    end
                    OP_J: begin
                        o_pc_jump = 1'b1;
                        w_next    = S_FETCH;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                o_mem_req      = rst_n;
                o_addr_sel_alu = 1'b1;
                o_mem_we       = rst_n && (i_opcode == OP_SW);
                if (i_mem_ready) begin
                    if (i_opcode == OP_SW) begin
                        w_next = S_FETCH;
                    end else begin
                        o_mdr_we = 1'b1;
                        w_next   = S_WB;
                    end
                end
            end
            S_WB: begin
                o_rf_we  = 1'b1;
                o_wb_rt  = (i_opcode != OP_RTYPE);
                o_wb_mdr = (i_opcode == OP_LW);
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core with one shared memory port: PC/IR/A/B/MDR
// datapath, ALU and register file here; sequencing lives in mc_ctrl.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] RST_PC = 32'h0,
    parameter int          NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int RIDX_W = $clog2(NREG);
    localparam logic [ADDR_W-1:0] PC_INIT = RST_PC[ADDR_W-1:0] & ~(ADDR_W'(3));

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir, r_a, r_b, r_mdr, r_alu_out;
    logic [31:0]       r_regs [NREG];

    state_t  w_state;
    alu_op_t w_alu_op;
    logic    w_addr_sel_alu, w_ir_we, w_ab_we, w_aluout_we, w_alu_src_imm;
    logic    w_mdr_we, w_rf_we, w_wb_rt, w_wb_mdr, w_pc_inc, w_pc_branch, w_pc_jump;

    logic [RIDX_W-1:0] w_rs, w_rt, w_rd, w_wr_idx;
    logic [31:0]       w_sext, w_alu_b, w_alu_y, w_wr_data;
    logic [ADDR_W-1:0] w_br_target, w_j_target;

    assign w_rs   = r_ir[21 +: RIDX_W];
    assign w_rt   = r_ir[16 +: RIDX_W];
    assign w_rd   = r_ir[11 +: RIDX_W];
    assign w_sext = {{16{r_ir[15]}}, r_ir[15:0]};

    mc_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_opcode       (r_ir[31:26]),
        .i_funct        (r_ir[5:0]),
        .i_mem_ready    (mem_ready),
        .i_a_eq_b       (r_a == r_b),
        .i_a_gtz        (!r_a[31] && (r_a != 32'h0)),
        .o_state        (w_state),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_addr_sel_alu (w_addr_sel_alu),
        .o_ir_we        (w_ir_we),
        .o_ab_we        (w_ab_we),
        .o_aluout_we    (w_aluout_we),
        .o_alu_src_imm  (w_alu_src_imm),
        .o_alu_op       (w_alu_op),
        .o_mdr_we       (w_mdr_we),
        .o_rf_we        (w_rf_we),
        .o_wb_rt        (w_wb_rt),
        .o_wb_mdr       (w_wb_mdr),
        .o_pc_inc       (w_pc_inc),
        .o_pc_branch    (w_pc_branch),
        .o_pc_jump      (w_pc_jump)
    );

    assign halted    = (w_state == S_HALT);
    assign pc_dbg    = r_pc;
    assign mem_addr  = w_addr_sel_alu ? {r_alu_out[ADDR_W-1:2], 2'b00} : r_pc;
    assign mem_wdata = r_b;

    always_comb begin
        w_alu_b = w_alu_src_imm ? w_sext : r_b;
        w_alu_y = r_a + w_alu_b;
        case (w_alu_op)
            ALU_SUB: w_alu_y = r_a - w_alu_b;
            ALU_AND: w_alu_y = r_a & w_alu_b;
            ALU_OR:  w_alu_y = r_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'h0, $signed(r_a) < $signed(w_alu_b)};
            default: w_alu_y = r_a + w_alu_b;
        endcase
    end

    // r_pc already points past the branch, so the offset is relative to PC+4.
    assign w_br_target = ADDR_W'(32'(r_pc) + (w_sext << 2));

    generate
        if (ADDR_W > 28) begin : g_j_hi
            assign w_j_target = {r_pc[ADDR_W-1:28], r_ir[25:0], 2'b00};
        end else begin : g_j_lo
            assign w_j_target = {r_ir[ADDR_W-3:0], 2'b00};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= PC_INIT;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mdr     <= '0;
            r_alu_out <= '0;
        end else begin
            if (w_ir_we)          r_ir <= mem_rdata;
            if (w_pc_inc)         r_pc <= r_pc + ADDR_W'(4);
            else if (w_pc_branch) r_pc <= w_br_target;
            else if (w_pc_jump)   r_pc <= w_j_target;
            if (w_ab_we) begin
                r_a <= r_regs[w_rs];
                r_b <= r_regs[w_rt];
            end
            if (w_aluout_we) r_alu_out <= w_alu_y;
            if (w_mdr_we)    r_mdr     <= mem_rdata;
        end
    end

    assign w_wr_idx  = w_wb_rt ? w_rt : w_rd;
    assign w_wr_data = w_wb_mdr ? r_mdr : r_alu_out;

    // Register 0 is never written, so it reads 0 forever after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_rf_we && (w_wr_idx != '0)) begin
            r_regs[w_wr_idx] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed-program bench: a wait-state memory responder doubles as the bus
// monitor and checks every transfer against a queue of expected transfers.
module tb_mips_multicycle_core;

    localparam int          EV_W   = 43;
    localparam logic [31:0] W_HALT = 32'hFC00_0000;

    logic        clk, rst_n;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [9:0]  mem_addr, pc_dbg;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0]     mem [256];
    int              rd_cyc [256];
    logic [EV_W-1:0] exp_q[$];
    int              wait_cfg, cyc, chk_cnt, pass_cnt;

    mips_multicycle_core #(.ADDR_W(10), .RST_PC(32'h0), .NREG(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc_dbg    (pc_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    function automatic logic [EV_W-1:0] ev(input logic we, input logic [9:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]    = W_HALT;
            rd_cyc[i] = 0;
        end
    endtask

    task automatic put(input logic [9:0] a, input logic [31:0] w);
        mem[a[9:2]] = w;
    endtask

    task automatic exp_fetches(input logic [9:0] lo, input logic [9:0] hi);
        for (logic [10:0] a = {1'b0, lo}; a <= {1'b0, hi}; a += 11'd4) exp_q.push_back(ev(1'b0, a[9:0], 32'h0));
    endtask

    task automatic reset_and_release();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_test(input string name, input int exp_halt, input logic [9:0] exp_pc);
        int n, req_seen, pc_moved;
        reset_and_release();
        #1 check({name, "_first_req"}, 64'(mem_req), 64'd1);
        n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        if (!halted) begin
            chk_cnt++;
            $display("FAIL %s_timeout: got running expected halted", name);
        end else begin
            check({name, "_halt_cyc"}, 64'(n), 64'(exp_halt));
        end
        check({name, "_pc"}, 64'(pc_dbg), 64'(exp_pc));
        check({name, "_trace_left"}, 64'(exp_q.size()), 64'd0);
        req_seen = 0;
        pc_moved = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mem_req || !halted) req_seen++;
            if (pc_dbg !== exp_pc) pc_moved++;
        end
        check({name, "_quiet"}, 64'(req_seen), 64'd0);
        check({name, "_pc_stable"}, 64'(pc_moved), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- responder + scoreboard monitor ----------------
    initial begin
        int wcnt;
        logic [EV_W-1:0] act, exp;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_req) begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end else if (wcnt < wait_cfg) begin
                mem_ready = 1'b0;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
                wcnt      = 0;
                mem_rdata = mem[mem_addr[9:2]];
                act = ev(mem_we, mem_addr, mem_we ? mem_wdata : 32'h0);
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL xfer_unexpected: got %0h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    check("xfer", 64'(act), 64'(exp));
                end
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                else        rd_cyc[mem_addr[9:2]] = cyc;
            end
        end
    end

    // ---------------- directed tests ----------------
    logic [31:0] t2_vals [8];

    initial begin
        cyc      = 0;
        chk_cnt  = 0;
        pass_cnt = 0;
        wait_cfg = 0;
        rst_n    = 1'b0;
        #1 check("rst_req", 64'({mem_req, mem_we, halted}), 64'd0);
        check("rst_pc", 64'(pc_dbg), 64'd0);

        // ALU sequence ending in opcode 0x3F
        clear_mem();
        put(10'h00, enc_i(6'h08, 0, 1, 16'd5));
        put(10'h04, enc_i(6'h08, 0, 2, 16'hFFFD));
        put(10'h08, enc_r(1, 2, 3, 6'h20));
        put(10'h0C, enc_r(2, 1, 4, 6'h2A));
        exp_fetches(10'h00, 10'h10);
        run_test("alu_halt", 18, 10'h14);

        // full ALU coverage, wraparound, $0 write discard, results stored
        clear_mem();
        put(10'h00, enc_i(6'h08, 0, 1, 16'd5));
        put(10'h04, enc_i(6'h08, 0, 2, 16'hFFFD));
        put(10'h08, enc_r(1, 2, 3, 6'h20));
        put(10'h0C, enc_r(2, 1, 4, 6'h2A));
        put(10'h10, enc_r(1, 2, 6, 6'h22));
        put(10'h14, enc_r(1, 2, 7, 6'h24));
        put(10'h18, enc_r(1, 2, 8, 6'h25));
        put(10'h1C, enc_r(1, 2, 9, 6'h2A));
        put(10'h20, enc_i(6'h08, 8, 10, 16'd4));
        put(10'h24, enc_i(6'h08, 0, 0, 16'd7));
        t2_vals = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd1, 32'd0};
        exp_fetches(10'h00, 10'h24);
        for (int k = 0; k < 8; k++) begin
            logic [4:0] src;
            src = (k == 7) ? 5'd0 : (k < 2) ? 5'(3 + k) : 5'(4 + k);
            put(10'(10'h28 + 4 * k), enc_i(6'h2B, 0, src, 16'(16'h80 + 4 * k)));
            exp_q.push_back(ev(1'b0, 10'(10'h28 + 4 * k), 32'h0));
            exp_q.push_back(ev(1'b1, 10'(10'h80 + 4 * k), t2_vals[k]));
        end
        exp_q.push_back(ev(1'b0, 10'h48, 32'h0));
        run_test("alu_store", 74, 10'h4C);

        // store then load through two wait states per access
        clear_mem();
        wait_cfg = 2;
        put(10'h00, enc_i(6'h08, 0, 1, 16'd5));
        put(10'h04, enc_i(6'h2B, 0, 1, 16'h40));
        put(10'h08, enc_i(6'h23, 0, 5, 16'h40));
        put(10'h0C, enc_i(6'h2B, 0, 5, 16'h44));
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h04, 32'h0));
        exp_q.push_back(ev(1'b1, 10'h40, 32'd5));
        exp_q.push_back(ev(1'b0, 10'h08, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h40, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h0C, 32'h0));
        exp_q.push_back(ev(1'b1, 10'h44, 32'd5));
        exp_q.push_back(ev(1'b0, 10'h10, 32'h0));
        run_test("lw_sw_wait", 35, 10'h14);
        check("sw_latency", 64'(rd_cyc[2] - rd_cyc[1]), 64'd8);
        check("lw_latency", 64'(rd_cyc[3] - rd_cyc[2]), 64'd9);
        wait_cfg = 0;

        // beq/bgtz taken and not taken, including a backward branch
        clear_mem();
        put(10'h00, enc_i(6'h08, 0, 1, 16'd1));
        put(10'h04, enc_i(6'h23, 0, 2, 16'hC0));
        put(10'h08, enc_i(6'h04, 1, 0, 16'd5));
        put(10'h0C, enc_i(6'h04, 1, 1, 16'd2));
        put(10'h18, enc_i(6'h07, 2, 0, 16'd3));
        put(10'h1C, enc_i(6'h07, 1, 0, 16'd2));
        put(10'h28, enc_i(6'h2B, 0, 2, 16'h84));
        put(10'h2C, enc_i(6'h04, 0, 0, 16'hFFF8));
        put(10'hC0, 32'h8000_0000);
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h04, 32'h0));
        exp_q.push_back(ev(1'b0, 10'hC0, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h08, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h0C, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h18, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h1C, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h28, 32'h0));
        exp_q.push_back(ev(1'b1, 10'h84, 32'h8000_0000));
        exp_q.push_back(ev(1'b0, 10'h2C, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h10, 32'h0));
        run_test("branch", 30, 10'h14);
        check("beq_nt_latency", 64'(rd_cyc[3] - rd_cyc[2]), 64'd3);
        check("beq_t_latency", 64'(rd_cyc[6] - rd_cyc[3]), 64'd3);

        // jumps, and $0 stays zero after addi $0
        clear_mem();
        put(10'h00, enc_i(6'h08, 0, 0, 16'd7));
        put(10'h04, enc_i(6'h2B, 0, 0, 16'h50));
        put(10'h08, enc_j(26'h4));
        put(10'h10, enc_j(26'h3));
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h04, 32'h0));
        exp_q.push_back(ev(1'b1, 10'h50, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h08, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h10, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h0C, 32'h0));
        run_test("jump", 16, 10'h10);

        // reset during a stalled store abandons it
        clear_mem();
        wait_cfg = 4;
        put(10'h00, enc_i(6'h08, 0, 1, 16'd9));
        put(10'h04, enc_i(6'h2B, 0, 1, 16'h60));
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h04, 32'h0));
        reset_and_release();
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk);
                #1 n++;
            end while (!(mem_req && mem_we) && n < 200);
            check("rst_sw_reached", 64'(mem_req && mem_we), 64'd1);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_abort_req", 64'({mem_req, mem_we, halted}), 64'd0);
        check("rst_abort_pc", 64'(pc_dbg), 64'd0);
        check("rst_abort_trace_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        check("rst_abort_no_write", 64'(mem[24]), 64'(W_HALT));
        wait_cfg = 0;
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        exp_q.push_back(ev(1'b0, 10'h04, 32'h0));
        exp_q.push_back(ev(1'b1, 10'h60, 32'd9));
        exp_q.push_back(ev(1'b0, 10'h08, 32'h0));
        run_test("rst_restart", 10, 10'h0C);

        // unsupported funct, then unsupported opcode
        clear_mem();
        put(10'h00, enc_r(1, 2, 3, 6'h18));
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        run_test("bad_funct", 2, 10'h04);

        clear_mem();
        put(10'h00, enc_i(6'h0F, 0, 1, 16'h1234));
        exp_q.push_back(ev(1'b0, 10'h00, 32'h0));
        run_test("bad_opcode", 2, 10'h04);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
